cheshire_rt_budget_arb: RTL and testbench

CHESHIRE_RT_BUDGET_ARB -- requirements
Module: cheshire_rt_budget_arb

---
 rtl/cheshire_rt_budget_arb.sv | 133 +++++++++++++
 tb/tb_cheshire_rt_budget_arb.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/cheshire_rt_budget_arb.sv
// Round-robin beat arbiter with per-manager budgets refilled each regulation period.
// Grant is combinational; a stalled grant (valid without ready) stays locked until it transfers.
module cheshire_rt_budget_arb #(
  parameter int NumMgr        = 4,
  parameter int BudgetWidth   = 16,
  parameter int PeriodWidth   = 16,
  parameter int DefaultBudget = 16,
  parameter int DefaultPeriod = 64,
  localparam int IdxW         = (NumMgr > 1) ? $clog2(NumMgr) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   enable_i,
  input  logic [NumMgr-1:0]      req_i,
  output logic [NumMgr-1:0]      gnt_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  input  logic                   cfg_budget_we_i,
  input  logic [IdxW-1:0]        cfg_idx_i,
  input  logic [BudgetWidth-1:0] cfg_budget_i,
  input  logic                   cfg_period_we_i,
  input  logic [PeriodWidth-1:0] cfg_period_i,
  output logic [NumMgr-1:0]      exhausted_o
);

  logic [BudgetWidth-1:0] budget_cfg  [NumMgr];
  logic [BudgetWidth-1:0] budget_left [NumMgr];
  logic [PeriodWidth-1:0] period_q;
  logic [PeriodWidth-1:0] period_cnt;
  logic [IdxW-1:0]        rr_ptr;
  logic                   lock_q;
  logic [IdxW-1:0]        lock_idx;

  logic [NumMgr-1:0] eligible;
  logic [NumMgr-1:0] exhausted;
  logic [NumMgr-1:0] grant;
  logic [IdxW-1:0]   gidx;
  logic [IdxW-1:0]   cand;
  logic [IdxW-1:0]   next_ptr;
  logic              found;
  logic              transfer;
  logic              reload;
  logic              do_reload;

  always_comb begin
    eligible  = '0;
    exhausted = '0;
    for (int i = 0; i < NumMgr; i++) begin
      eligible[i]  = req_i[i] & (~enable_i | (budget_left[i] != '0));
      exhausted[i] = enable_i & (budget_left[i] == '0);
    end
  end

  // A held grant ignores budget; if its requester drops, fall back to a fresh search.
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    cand  = '0;
    if (lock_q && req_i[lock_idx]) begin
      found = 1'b1;
      gidx  = lock_idx;
    end else begin
      for (int k = 0; k < NumMgr; k++) begin
        cand = IdxW'((int'(rr_ptr) + k) % NumMgr);
        if (!found && eligible[cand]) begin
          found = 1'b1;
          gidx  = cand;
        end
      end
    end
  end

  always_comb begin
    grant = '0;
    if (found) grant[gidx] = 1'b1;
  end

  assign gnt_o       = rst_i ? '0 : grant;
  assign valid_o     = |gnt_o;
  assign exhausted_o = rst_i ? '0 : exhausted;
  assign transfer    = valid_o & ready_i;
  assign next_ptr    = (gidx == IdxW'(NumMgr - 1)) ? '0 : gidx + IdxW'(1);
  assign reload      = (period_q == '0) || (period_cnt == period_q - PeriodWidth'(1));
  // A period rewrite restarts the count without refilling budgets.
  assign do_reload   = reload & ~cfg_period_we_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumMgr; i++) begin
        budget_cfg[i]  <= BudgetWidth'(DefaultBudget);
        budget_left[i] <= BudgetWidth'(DefaultBudget);
      end
      period_q   <= PeriodWidth'(DefaultPeriod);
      period_cnt <= '0;
      rr_ptr     <= '0;
      lock_q     <= 1'b0;
      lock_idx   <= '0;
    end else begin
      if (transfer) begin
        rr_ptr <= next_ptr;
        lock_q <= 1'b0;
      end else if (valid_o) begin
        lock_q   <= 1'b1;
        lock_idx <= gidx;
      end else begin
        lock_q <= 1'b0;
      end

      if (cfg_period_we_i) begin
        period_q   <= cfg_period_i;
        period_cnt <= '0;
      end else if (reload) begin
        period_cnt <= '0;
      end else begin
        period_cnt <= period_cnt + PeriodWidth'(1);
      end

      // Refill wins over a same-cycle charge, so that beat is free.
      for (int i = 0; i < NumMgr; i++) begin
        if (do_reload) begin
          budget_left[i] <= budget_cfg[i];
        end else if (transfer && enable_i && gidx == IdxW'(i) && budget_left[i] != '0) begin
          budget_left[i] <= budget_left[i] - BudgetWidth'(1);
        end
      end

      if (cfg_budget_we_i && int'(cfg_idx_i) < NumMgr) begin
        budget_cfg[cfg_idx_i] <= cfg_budget_i;
      end
    end
  end

endmodule

// File: tb/tb_cheshire_rt_budget_arb.sv
// Scoreboard bench: directed stimulus pushes per-cycle expected grant/exhausted values, a negedge monitor pops and compares.
module tb_cheshire_rt_budget_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [3:0]  req;
  logic [3:0]  gnt;
  logic        valid;
  logic        ready;
  logic        cfg_budget_we;
  logic [1:0]  cfg_idx;
  logic [15:0] cfg_budget;
  logic        cfg_period_we;
  logic [15:0] cfg_period;
  logic [3:0]  exhausted;

  always #5 clk = ~clk;

  cheshire_rt_budget_arb dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .enable_i       (enable),
    .req_i          (req),
    .gnt_o          (gnt),
    .valid_o        (valid),
    .ready_i        (ready),
    .cfg_budget_we_i(cfg_budget_we),
    .cfg_idx_i      (cfg_idx),
    .cfg_budget_i   (cfg_budget),
    .cfg_period_we_i(cfg_period_we),
    .cfg_period_i   (cfg_period),
    .exhausted_o    (exhausted)
  );

  typedef struct packed {
    logic [7:0] id;
    logic [3:0] gnt;
    logic [3:0] exh;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   test_id = 0;
  int   cyc = 0;

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (gnt !== e.gnt || valid !== (|e.gnt) || exhausted !== e.exh) begin
        errors++;
        $display("FAIL t%0d cycle %0d gnt/valid/exhausted: got %b/%b/%b expected %b/%b/%b",
                 e.id, cyc, gnt, valid, exhausted, e.gnt, |e.gnt, e.exh);
      end
    end
  end

  task automatic step(input logic rs, input logic [3:0] r, input logic rdy, input logic en,
                      input logic [3:0] eg, input logic [3:0] ex);
    exp_t e;
    rst    = rs;
    req    = r;
    ready  = rdy;
    enable = en;
    e.id   = test_id[7:0];
    e.gnt  = eg;
    e.exh  = ex;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    cfg_budget_we = 1'b0;
    cfg_period_we = 1'b0;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; req = '0; ready = 1'b0;
    cfg_budget_we = 1'b0; cfg_idx = '0; cfg_budget = '0;
    cfg_period_we = 1'b0; cfg_period = '0;
    @(posedge clk);
    #1;

    // reset forces outputs low even with requests present, then idle state
    test_id = 0;
    step(1, 4'b1111, 1, 1, 4'b0000, 4'b0000);
    step(1, 4'b1111, 1, 1, 4'b0000, 4'b0000);
    step(0, 4'b0000, 1, 1, 4'b0000, 4'b0000);

    // plain round-robin, regulation off
    test_id = 1;
    step(1, 4'b0000, 1, 0, 4'b0000, 4'b0000);
    step(0, 4'b1111, 1, 0, 4'b0001, 4'b0000);
    step(0, 4'b1111, 1, 0, 4'b0010, 4'b0000);
    step(0, 4'b1111, 1, 0, 4'b0100, 4'b0000);
    step(0, 4'b1111, 1, 0, 4'b1000, 4'b0000);
    step(0, 4'b1111, 1, 0, 4'b0001, 4'b0000);

    // budget 2 for mgr0, period 64: two grants, starve, refill after 64 cycles
    test_id = 2;
    step(1, 4'b0000, 1, 1, 4'b0000, 4'b0000);
    cfg_budget_we = 1'b1; cfg_idx = 2'd0; cfg_budget = 16'd2;
    cfg_period_we = 1'b1; cfg_period = 16'd1;
    step(0, 4'b0000, 1, 1, 4'b0000, 4'b0000);
    step(0, 4'b0000, 1, 1, 4'b0000, 4'b0000);
    cfg_period_we = 1'b1; cfg_period = 16'd64;
    step(0, 4'b0000, 1, 1, 4'b0000, 4'b0000);
    step(0, 4'b0001, 1, 1, 4'b0001, 4'b0000);
    step(0, 4'b0001, 1, 1, 4'b0001, 4'b0000);
    for (int i = 0; i < 62; i++) step(0, 4'b0001, 1, 1, 4'b0000, 4'b0001);
    step(0, 4'b0001, 1, 1, 4'b0001, 4'b0000);
    step(0, 4'b0001, 1, 1, 4'b0001, 4'b0000);
    step(0, 4'b0001, 1, 1, 4'b0000, 4'b0001);
    step(1, 4'b0001, 1, 1, 4'b0000, 4'b0000);
    step(0, 4'b0001, 1, 1, 4'b0001, 4'b0000);

    // stall lock on mgr1, then wrap to mgr0; dropped locked request re-arbitrates
    test_id = 3;
    step(1, 4'b0000, 1, 1, 4'b0000, 4'b0000);
    step(0, 4'b0001, 1, 1, 4'b0001, 4'b0000);
    for (int i = 0; i < 5; i++) step(0, 4'b0011, 0, 1, 4'b0010, 4'b0000);
    step(0, 4'b0011, 1, 1, 4'b0010, 4'b0000);
    step(0, 4'b0011, 1, 1, 4'b0001, 4'b0000);
    step(0, 4'b0011, 0, 1, 4'b0010, 4'b0000);
    step(0, 4'b0001, 1, 1, 4'b0001, 4'b0000);

    // transfer in a reload cycle is not charged: three full grants follow
    test_id = 4;
    step(1, 4'b0000, 1, 1, 4'b0000, 4'b0000);
    cfg_budget_we = 1'b1; cfg_idx = 2'd1; cfg_budget = 16'd3;
    cfg_period_we = 1'b1; cfg_period = 16'd1;
    step(0, 4'b0000, 1, 1, 4'b0000, 4'b0000);
    step(0, 4'b0000, 1, 1, 4'b0000, 4'b0000);
    cfg_period_we = 1'b1; cfg_period = 16'd4;
    step(0, 4'b0000, 1, 1, 4'b0000, 4'b0000);
    for (int i = 0; i < 3; i++) step(0, 4'b0000, 1, 1, 4'b0000, 4'b0000);
    step(0, 4'b0010, 1, 1, 4'b0010, 4'b0000);
    for (int i = 0; i < 3; i++) step(0, 4'b0010, 1, 1, 4'b0010, 4'b0000);
    step(0, 4'b0010, 1, 1, 4'b0000, 4'b0010);
    step(0, 4'b0010, 1, 1, 4'b0010, 4'b0000);

    // period rewrite at count 40: next refill exactly 10 cycles later
    test_id = 5;
    step(1, 4'b0000, 1, 1, 4'b0000, 4'b0000);
    cfg_budget_we = 1'b1; cfg_idx = 2'd2; cfg_budget = 16'd0;
    for (int i = 0; i < 40; i++) step(0, 4'b0000, 1, 1, 4'b0000, 4'b0000);
    cfg_period_we = 1'b1; cfg_period = 16'd10;
    step(0, 4'b0000, 1, 1, 4'b0000, 4'b0000);
    for (int i = 0; i < 10; i++) step(0, 4'b0000, 1, 1, 4'b0000, 4'b0000);
    step(0, 4'b0000, 1, 1, 4'b0000, 4'b0100);
    step(0, 4'b0000, 1, 1, 4'b0000, 4'b0100);

    // reset during a locked stall
    test_id = 6;
    step(1, 4'b0000, 1, 1, 4'b0000, 4'b0000);
    step(0, 4'b0011, 1, 1, 4'b0001, 4'b0000);
    step(0, 4'b0011, 0, 1, 4'b0010, 4'b0000);
    step(1, 4'b0011, 0, 1, 4'b0000, 4'b0000);
    step(0, 4'b0011, 1, 1, 4'b0001, 4'b0000);
    step(0, 4'b0011, 1, 1, 4'b0010, 4'b0000);

    #10;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
